// File: rtl/tc_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_timer_pkg
// Brief    : State encoding, default sizes and the round-robin first-set scan
//            shared by tc_timer_arbiter and its counter.
// Revision : 1.0 - initial release
// ============================================================================
package tc_timer_pkg;

  localparam int c_DEF_N    = 4;
  localparam int c_DEF_W    = 8;
  localparam int c_SCAN_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n-1 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  w_sel;
    logic        w_found;
    int unsigned w_idx;
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < c_SCAN_MAX; i++) begin
      if (i < n) begin
        w_idx = 32'(ptr) + i;
        if (w_idx >= n) w_idx = w_idx - n;
        if (!w_found && req[w_idx[2:0]]) begin
          w_sel   = w_idx[2:0];
          w_found = 1'b1;
        end
      end
    end
    return w_sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_counter.sv
`default_nettype none
// ============================================================================
// Module   : tc_counter
// Brief    : W-bit up-counter with latched limit, load-clear, enable and a
//            terminal-count flag; counts 0..limit and then holds.
// Revision : 1.0 - initial release
// ============================================================================
module tc_counter import tc_timer_pkg::*; #(
  parameter int W = c_DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_at_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_limit;
  logic         w_at_limit;

  // Compare before increment, so a limit of all-ones never wraps.
  assign w_at_limit = (r_cnt == r_limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_limit <= i_load_val;
    end else if (i_clr) begin
      r_cnt   <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt   <= r_cnt + W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = w_at_limit;
  assign o_tc       = i_en && w_at_limit;

endmodule
`default_nettype wire

// File: rtl/tc_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tc_timer_arbiter
// Brief    : Round-robin owner of one shared terminal-count timer across N
//            requesters. Define FIXED_PRIO_EN for lowest-index-wins arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tc_timer_arbiter import tc_timer_pkg::*; #(
  parameter int N  = c_DEF_N,
  parameter int W  = c_DEF_W,
  parameter int IW = 2
) (
  input  logic           Clock,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [IW-1:0]  owner,
  output logic [W-1:0]   cnt,
  output logic           tc
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] w_pick;
  logic [W-1:0]  w_load_val;
  logic [N-1:0]  w_owner_oh;
  logic          w_load;
  logic          w_clr;
  logic          w_en;
  logic          w_at_limit;
  logic          w_own_req;

  assign w_own_req  = req[r_owner];
  assign w_load_val = len[int'(w_pick)*W +: W];

`ifdef FIXED_PRIO_EN
  assign w_pick = IW'(rr_pick(8'(req), 3'd0, N));
`else
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_owner_inc;

  assign w_owner_inc = (r_owner == IW'(N-1)) ? '0 : r_owner + IW'(1);

  // Every exit from a job (abort or completion) clears the counter, so
  // the same strobe advances the fairness pointer past the owner.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_clr) begin
      r_ptr <= w_owner_inc;
    end
  end

  assign w_pick = IW'(rr_pick(8'(req), 3'(r_ptr), N));
`endif

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // An owner dropping its request aborts the job, even on the terminal cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_load      = 1'b1;
          w_owner_nxt = w_pick;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_own_req) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_en = 1'b1;
          if (w_at_limit) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  tc_counter #(.W(W)) u_counter (
    .clk        (Clock),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .o_cnt      (cnt),
    .o_at_limit (w_at_limit),
    .o_tc       (tc)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_owner_oh
    assign w_owner_oh[gi] = (r_owner == IW'(gi));
  end

  assign busy  = (r_state != ST_IDLE);
  assign gnt   = busy ? w_owner_oh : '0;
  assign done  = (r_state == ST_DONE) ? w_owner_oh : '0;
  assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_tc_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_timer_arbiter
// Brief    : Scoreboard bench for tc_timer_arbiter: a job-level timestamp model
//            predicts grant/tc/done events and the counter value per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_timer_arbiter;

  localparam int c_N       = 4;
  localparam int c_W       = 8;
  localparam int c_IW      = 2;
  localparam int c_EV_GNT  = 0;
  localparam int c_EV_TC   = 1;
  localparam int c_EV_DONE = 2;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    int val;
  } ev_t;

  logic               Clock = 1'b0;
  logic               rst;
  logic [c_N-1:0]     req;
  logic [c_N*c_W-1:0] len;
  logic [c_N-1:0]     gnt;
  logic [c_N-1:0]     done;
  logic               busy;
  logic [c_IW-1:0]    owner;
  logic [c_W-1:0]     cnt;
  logic               tc;

  tc_timer_arbiter #(.N(c_N), .W(c_W), .IW(c_IW)) dut (
    .Clock (Clock),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .cnt   (cnt),
    .tc    (tc)
  );

  always #5 Clock = ~Clock;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   run_en = 1'b0;
  ev_t  exp_q[$];

  // Job-level reference: when the timer frees up and which job it serves.
  bit m_busy      = 1'b0;
  int m_owner     = 0;
  int m_lim       = 0;
  int m_start     = 0;
  int m_ptr       = 0;
  int m_idle_from = 0;
  int m_done_cyc  = -1;
  int m_exp_cnt   = 0;

  logic [c_N-1:0] prev_gnt  = '0;
  logic [c_N-1:0] done_seen = '0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      c_EV_GNT: return "grant";
      c_EV_TC:  return "tc";
      default:  return "done";
    endcase
  endfunction

  function automatic int oh_idx(input logic [c_N-1:0] v);
    for (int i = 0; i < c_N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [c_W-1:0] rand_len();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 15) return 8'hFF;
    if (r == 14) return 8'($urandom_range(20, 60));
    return 8'(r % 7);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic observe(input int kind, input int idx, input int val);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event %s: got idx %0d at cycle %0d, expected no event", ev_name(kind), idx, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx || e.cyc != cyc || e.val != val) begin
        n_fail++;
        $display("FAIL event: got %s idx %0d cycle %0d val %0d, expected %s idx %0d cycle %0d val %0d",
                 ev_name(kind), idx, cyc, val, ev_name(e.kind), e.idx, e.cyc, e.val);
      end
    end
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_owner     = 0;
    m_lim       = 0;
    m_start     = 0;
    m_ptr       = 0;
    m_idle_from = 0;
    m_done_cyc  = -1;
    m_exp_cnt   = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int w;
    if (m_busy) m_exp_cnt = cyc - m_start;
    else if (cyc == m_done_cyc) m_exp_cnt = m_lim;
    else m_exp_cnt = 0;

    if (!m_busy) begin
      if (cyc >= m_idle_from && req != '0) begin
        w = -1;
        for (int k = 0; k < c_N; k++) begin
          int idx;
`ifdef FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_ptr + k) % c_N;
`endif
          if (w < 0 && req[idx]) w = idx;
        end
        m_owner = w;
        m_lim   = int'(len[w*c_W +: c_W]);
        m_start = cyc + 1;
        m_busy  = 1'b1;
        exp_q.push_back('{c_EV_GNT, w, cyc + 1, w});
      end
    end else if (!req[m_owner]) begin
      m_busy      = 1'b0;
      m_idle_from = cyc + 1;
      m_ptr       = (m_owner + 1) % c_N;
    end else if (cyc - m_start == m_lim) begin
      exp_q.push_back('{c_EV_TC, m_owner, cyc, m_lim});
      exp_q.push_back('{c_EV_DONE, m_owner, cyc + 1, m_lim});
      m_done_cyc  = cyc + 1;
      m_busy      = 1'b0;
      m_idle_from = cyc + 2;
      m_ptr       = (m_owner + 1) % c_N;
    end
  endtask

  // Model runs after stimulus settles for the cycle.
  always @(posedge Clock) begin
    #2;
    if (!rst) model_reset();
    else if (run_en) model_step();
  end

  // Monitor: compares every DUT output event against the queue head.
  always @(negedge Clock) begin : b_mon
    int gi;
    if (rst && run_en) begin
      gi = oh_idx(gnt);
      check("cnt", int'(cnt), m_exp_cnt);
      check("busy", int'(busy), int'(gnt != '0));
      if (gnt != '0 && prev_gnt == '0) observe(c_EV_GNT, gi, int'(owner));
      if (tc) observe(c_EV_TC, gi, int'(cnt));
      if (done != '0) observe(c_EV_DONE, oh_idx(done), int'(cnt));
      n_chk++;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_fail++;
        $display("FAIL missing %s idx %0d: got nothing at cycle %0d, expected at cycle %0d",
                 ev_name(exp_q[0].kind), exp_q[0].idx, cyc, exp_q[0].cyc);
        exp_q.delete(0);
      end
    end
    prev_gnt  = gnt;
    done_seen = done;
  end

  task automatic tick(input bit rand_en, input bit hold);
    @(posedge Clock);
    #1;
    for (int i = 0; i < c_N; i++) begin
      if (req[i] && done_seen[i] && !hold) begin
        req[i] = 1'b0;
      end else if (rand_en) begin
        if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            req[i] = 1'b1;
            len[i*c_W +: c_W] = rand_len();
          end
        end else if (gnt[i] && $urandom_range(0, 59) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          len[i*c_W +: c_W] = rand_len();
        end
      end
    end
  endtask

  task automatic drain(input int max_cyc, input string name);
    int k;
    k = 0;
    while (k < max_cyc && !(req == '0 && !busy)) begin
      tick(1'b0, 1'b0);
      k++;
    end
    check({name, " drain"}, int'(req == '0 && !busy), 1);
    repeat (2) tick(1'b0, 1'b0);
  endtask

  initial begin : b_main
    bit found;
    rst = 1'b0;
    req = '0;
    len = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset gnt", int'(gnt), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    check("reset tc", int'(tc), 0);
    check("reset cnt", int'(cnt), 0);
    check("reset owner", int'(owner), 0);
    rst    = 1'b1;
    run_en = 1'b1;

    // Single job, limit 5.
    len[0*c_W +: c_W] = 8'd5;
    req = 4'b0001;
    drain(40, "single");

    // All four held continuously, limit 2 each.
    for (int i = 0; i < c_N; i++) len[i*c_W +: c_W] = 8'd2;
    req = 4'b1111;
    repeat (25) tick(1'b0, 1'b1);
    drain(100, "hold all");

    // Zero limit: one RUN cycle.
    len[0*c_W +: c_W] = 8'd0;
    req = 4'b0001;
    drain(20, "zero limit");

    // Abort at cnt 4, then the scan resumes after the aborted owner.
    len[2*c_W +: c_W] = 8'd10;
    req = 4'b0100;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1'b0, 1'b0);
      if (gnt[2] && cnt == 8'd4) found = 1'b1;
    end
    check("abort reached cnt 4", int'(found), 1);
    len[0*c_W +: c_W] = 8'd1;
    len[1*c_W +: c_W] = 8'd1;
    len[3*c_W +: c_W] = 8'd1;
    req = 4'b1011;
    drain(60, "abort");

    // Randomised traffic with occasional aborts and long limits.
    repeat (3000) tick(1'b1, 1'b0);
    drain(1500, "random");

    // Reset in the middle of a job.
    len[0*c_W +: c_W] = 8'd20;
    req = 4'b0001;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1'b0, 1'b0);
      if (gnt[0] && cnt == 8'd3) found = 1'b1;
    end
    check("mid-run reached cnt 3", int'(found), 1);
    run_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("mid reset gnt", int'(gnt), 0);
    check("mid reset done", int'(done), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset tc", int'(tc), 0);
    check("mid reset cnt", int'(cnt), 0);
    check("mid reset owner", int'(owner), 0);
    req = '0;
    @(posedge Clock);
    #1;
    rst = 1'b1;
    len[1*c_W +: c_W] = 8'd3;
    len[3*c_W +: c_W] = 8'd2;
    req    = 4'b1010;
    run_en = 1'b1;
    tick(1'b0, 1'b0);
`ifdef FIXED_PRIO_EN
    check("post-reset grant", int'(gnt), 2);
`else
    check("post-reset grant", int'(gnt), 2);
`endif
    drain(40, "post reset");

    run_en = 1'b0;
    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
